block_plotter: RTL and testbench
================================

BLOCK_PLOTTER -- requirements
Module: block_plotter

Interface
REQ-001 Parameter BLOCK_W, default 20, block width in pixels (legal 1..255).
REQ-002 Parameter BLOCK_H, default 4, block height in pixels (legal 1..127).
REQ-003 Parameter ERASE_COLOUR, default 3'b000, background colour used when erasing.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 resetn  in  1  reset, synchronous and active-high: one clock; reset is synchronous and active-high.
REQ-006 count_x_enable  in  1  plot request from controller; held high for the whole plot or erase.
REQ-007 colour_erase_enable  in  1  1 = erase (use ERASE_COLOUR), 0 = draw (use colour_in).
REQ-008 x_in  in  8  block origin x (top-left), from load stage.
REQ-009 y_in  in  7  block origin y (top-left), from load stage.
REQ-010 colour_in  in  3  block draw colour.
REQ-011 x_out  out  8  current pixel x to VGA adapter.
REQ-012 y_out  out  7  current pixel y to VGA adapter.
REQ-013 colour_out  out  3  current pixel colour to VGA adapter.
REQ-014 plot_valid  out  1  high exactly on cycles presenting a new block pixel.
REQ-015 done_plot  out  1  block fully drawn/erased; level, held until request drops.

Function
REQ-016 The FSM SHALL have states IDLE, DRAW, DONE, all outputs registered.
REQ-017 IDLE: on count_x_enable=1 SHALL latch x_in, y_in, and colour (ERASE_COLOUR if colour_erase_enable=1 else colour_in), clear cx, cy to 0, go to DRAW.
REQ-018 IDLE with count_x_enable=0 SHALL remain IDLE.
REQ-019 DRAW: x_out = x_base+cx, y_out = y_base+cy, colour_out = latched colour, plot_valid=1.
REQ-020 DRAW SHALL scan row-major: cx increments each cycle; at cx=BLOCK_W-1 cx wraps to 0 and cy increments.
REQ-021 DRAW at (cx=BLOCK_W-1, cy=BLOCK_H-1) SHALL go to DONE next edge; DRAW lasts exactly BLOCK_W*BLOCK_H cycles.
REQ-022 DONE: done_plot=1, plot_valid=0, x_out/y_out/colour_out hold last pixel (re-writes of it harmless).
REQ-023 DONE SHALL go to IDLE on the first edge with count_x_enable=0; done_plot falls that same edge.
REQ-024 count_x_enable=0 during DRAW SHALL abort to IDLE next edge; done_plot not asserted; no further pixels.
REQ-025 x_in, y_in, colour_in, colour_erase_enable changes during DRAW/DONE SHALL be ignored (latched values used).
REQ-026 Coordinate sums SHALL wrap modulo 256 (x) and 128 (y); no saturation, no clipping.
REQ-027 First pixel plot_valid SHALL appear 1 cycle after the edge sampling count_x_enable=1 in IDLE.
REQ-028 In IDLE plot_valid=0, done_plot=0; x_out/y_out/colour_out hold previous values.

Reset
REQ-029 resetn=1 at an edge SHALL force IDLE, cx=cy=0, x_out=0, y_out=0, colour_out=0, plot_valid=0, done_plot=0, from any state.
REQ-030 Reset SHALL take priority over count_x_enable on the same edge.
REQ-031 After reset deassertion a plot SHALL start only on a fresh sample of count_x_enable=1 in IDLE.

Verification (BLOCK_W=4, BLOCK_H=2 unless noted)
REQ-032 Draw: x_in=10, y_in=20, colour_in=3'b101, request held -> 8 plot_valid cycles (10,20)..(13,20),(10,21)..(13,21), colour 101, then done_plot=1 until request drops.
REQ-033 Erase: same origin, colour_erase_enable=1, colour_in=3'b111 -> 8 pixels all colour 000, done_plot then asserted.
REQ-034 Wrap: x_in=254, y_in=127 -> x sequence 254,255,0,1; y 127 then 0.
REQ-035 Abort: drop count_x_enable after 3 pixels -> IDLE next edge, no done_plot, no 4th pixel; new request restarts at (cx,cy)=(0,0).
REQ-036 Reset mid-DRAW (pixel 5) -> next cycle all outputs 0, IDLE; input change mid-DRAW (x_in 10->50) -> sequence unaffected.
REQ-037 Defaults (20x4): request held -> exactly 80 plot_valid cycles, done_plot on cycle 81 after start.

Source files
------------

// File: rtl/block_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : block_plotter
// Purpose  : Scans a BLOCK_W x BLOCK_H rectangle of pixels row-major from a
//            latched top-left origin and presents one pixel per cycle to a
//            VGA adapter, in either the request colour or the erase colour.
// Ports    : clk                 - sole clock, rising edge
//            resetn              - synchronous, active-high reset
//            count_x_enable      - plot request, held for whole plot/erase
//            colour_erase_enable - 1 = erase colour, 0 = colour_in
//            x_in / y_in         - block origin (top-left)
//            colour_in           - block draw colour
//            x_out / y_out       - current pixel coordinate (registered)
//            colour_out          - current pixel colour (registered)
//            plot_valid          - high on cycles presenting a new pixel
//            done_plot           - block complete; held until request drops
// Revision : 1.0 - initial release
// ============================================================================
module block_plotter #(
    parameter int         BLOCK_W      = 20,
    parameter int         BLOCK_H      = 4,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       count_x_enable,
    input  logic       colour_erase_enable,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot_valid,
    output logic       done_plot
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DRAW = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [7:0] c_LAST_X = 8'(BLOCK_W - 1);
    localparam logic [6:0] c_LAST_Y = 7'(BLOCK_H - 1);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic [7:0] r_x_base;
    logic [6:0] r_y_base;
    logic [2:0] r_colour;
    logic [7:0] r_cx;
    logic [6:0] r_cy;

    logic [7:0] r_x_out;
    logic [6:0] r_y_out;
    logic [2:0] r_colour_out;
    logic       r_plot_valid;
    logic       r_done_plot;

    logic [7:0] w_x_nxt;
    logic [6:0] w_y_nxt;
    logic [2:0] w_colour_nxt;
    logic       w_plot_valid_nxt;
    logic       w_done_plot_nxt;

    logic       w_last_pixel;

    assign w_last_pixel = (r_cx == c_LAST_X) && (r_cy == c_LAST_Y);

    // State register
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping the request always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (count_x_enable) w_state_nxt = c_DRAW;
            end
            c_DRAW: begin
                if (!count_x_enable)   w_state_nxt = c_IDLE;
                else if (w_last_pixel) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                if (!count_x_enable) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. Coordinates hold
    // outside DRAW so the adapter keeps seeing the last pixel.
    always_comb begin
        w_x_nxt          = r_x_out;
        w_y_nxt          = r_y_out;
        w_colour_nxt     = r_colour_out;
        w_plot_valid_nxt = 1'b0;
        w_done_plot_nxt  = 1'b0;
        case (r_state)
            c_DRAW: begin
                if (count_x_enable) begin
                    // 8/7-bit sums wrap naturally at the screen edge
                    w_x_nxt          = r_x_base + r_cx;
                    w_y_nxt          = r_y_base + r_cy;
                    w_colour_nxt     = r_colour;
                    w_plot_valid_nxt = 1'b1;
                end
            end
            c_DONE: begin
                w_done_plot_nxt = count_x_enable;
            end
            default: ;
        endcase
    end

    // Datapath: origin/colour latch, row-major scan counters, output registers
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_x_base     <= 8'd0;
            r_y_base     <= 7'd0;
            r_colour     <= 3'd0;
            r_cx         <= 8'd0;
            r_cy         <= 7'd0;
            r_x_out      <= 8'd0;
            r_y_out      <= 7'd0;
            r_colour_out <= 3'd0;
            r_plot_valid <= 1'b0;
            r_done_plot  <= 1'b0;
        end else begin
            r_x_out      <= w_x_nxt;
            r_y_out      <= w_y_nxt;
            r_colour_out <= w_colour_nxt;
            r_plot_valid <= w_plot_valid_nxt;
            r_done_plot  <= w_done_plot_nxt;
            case (r_state)
                c_IDLE: begin
                    if (count_x_enable) begin
                        r_x_base <= x_in;
                        r_y_base <= y_in;
                        r_colour <= colour_erase_enable ? ERASE_COLOUR : colour_in;
                        r_cx     <= 8'd0;
                        r_cy     <= 7'd0;
                    end
                end
                c_DRAW: begin
                    if (count_x_enable) begin
                        if (r_cx == c_LAST_X) begin
                            r_cx <= 8'd0;
                            r_cy <= r_cy + 7'd1;
                        end else begin
                            r_cx <= r_cx + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign colour_out = r_colour_out;
    assign plot_valid = r_plot_valid;
    assign done_plot  = r_done_plot;

endmodule
`default_nettype wire

// File: tb/tb_block_plotter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_block_plotter
// Purpose  : Self-checking bench for block_plotter. A 4x2 instance covers the
//            directed and random cases; a default-size instance covers 20x4.
//            Expected pixels come from origin + (k mod W, k div W).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_plotter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       req_s;
    logic       req_d;
    logic       erase;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;

    logic [7:0] xs, xd;
    logic [6:0] ys, yd;
    logic [2:0] cs, cd;
    logic       vs, vd, ds, dd;

    logic       sel;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [2:0] oc;
    logic       ov, od;

    int checks = 0;
    int errors = 0;

    always_comb begin
        ox = sel ? xd : xs;
        oy = sel ? yd : ys;
        oc = sel ? cd : cs;
        ov = sel ? vd : vs;
        od = sel ? dd : ds;
    end

    block_plotter #(.BLOCK_W(4), .BLOCK_H(2), .ERASE_COLOUR(3'b000)) dut_s (
        .clk                 (clk),
        .resetn              (resetn),
        .count_x_enable      (req_s),
        .colour_erase_enable (erase),
        .x_in                (x_in),
        .y_in                (y_in),
        .colour_in           (colour_in),
        .x_out               (xs),
        .y_out               (ys),
        .colour_out          (cs),
        .plot_valid          (vs),
        .done_plot           (ds)
    );

    block_plotter dut_d (
        .clk                 (clk),
        .resetn              (resetn),
        .count_x_enable      (req_d),
        .colour_erase_enable (erase),
        .x_in                (x_in),
        .y_in                (y_in),
        .colour_in           (colour_in),
        .x_out               (xd),
        .y_out               (yd),
        .colour_out          (cd),
        .plot_valid          (vd),
        .done_plot           (dd)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v);
        if (sel) req_d = v;
        else     req_s = v;
    endtask

    // Full plot with inputs scrambled after the start edge; they must be ignored.
    task automatic run_plot(input logic use_def, input logic [7:0] x0, input logic [6:0] y0,
                            input logic [2:0] col, input logic er, input int w, input int h);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        sel = use_def;
        x_in = x0; y_in = y0; colour_in = col; erase = er;
        ec = er ? 3'b000 : col;
        ex = x0; ey = y0;
        set_req(1'b1);
        tick;
        check("start_latency_valid", 32'(ov), 32'd0);
        for (int k = 0; k < w * h; k++) begin
            x_in = 8'($urandom); y_in = 7'($urandom);
            colour_in = 3'($urandom); erase = 1'($urandom);
            tick;
            ex = 8'((int'(x0) + k % w) % 256);
            ey = 7'((int'(y0) + k / w) % 128);
            check($sformatf("pix%0d_valid", k), 32'(ov), 32'd1);
            check($sformatf("pix%0d_x", k), 32'(ox), 32'(ex));
            check($sformatf("pix%0d_y", k), 32'(oy), 32'(ey));
            check($sformatf("pix%0d_colour", k), 32'(oc), 32'(ec));
            check($sformatf("pix%0d_done", k), 32'(od), 32'd0);
        end
        tick;
        check("done_set", 32'(od), 32'd1);
        check("done_valid_low", 32'(ov), 32'd0);
        check("done_x_hold", 32'(ox), 32'(ex));
        check("done_y_hold", 32'(oy), 32'(ey));
        check("done_colour_hold", 32'(oc), 32'(ec));
        repeat (2) tick;
        check("done_held", 32'(od), 32'd1);
        check("done_held_valid", 32'(ov), 32'd0);
        set_req(1'b0);
        tick;
        check("release_done", 32'(od), 32'd0);
        check("release_valid", 32'(ov), 32'd0);
        check("release_x_hold", 32'(ox), 32'(ex));
    endtask

    initial begin
        resetn = 1'b1; req_s = 1'b0; req_d = 1'b0; sel = 1'b0;
        erase = 1'b0; x_in = 8'd0; y_in = 7'd0; colour_in = 3'd0;
        repeat (2) tick;
        check("rst_s_x", 32'(xs), 32'd0);
        check("rst_s_y", 32'(ys), 32'd0);
        check("rst_s_c", 32'(cs), 32'd0);
        check("rst_s_v", 32'(vs), 32'd0);
        check("rst_s_d", 32'(ds), 32'd0);
        check("rst_d_v", 32'(vd), 32'd0);
        check("rst_d_d", 32'(dd), 32'd0);
        resetn = 1'b0;
        repeat (3) tick;
        check("idle_stays_v", 32'(vs), 32'd0);
        check("idle_stays_d", 32'(ds), 32'd0);

        // Draw, erase, wrap
        run_plot(1'b0, 8'd10, 7'd20, 3'b101, 1'b0, 4, 2);
        run_plot(1'b0, 8'd10, 7'd20, 3'b111, 1'b1, 4, 2);
        run_plot(1'b0, 8'd254, 7'd127, 3'b011, 1'b0, 4, 2);

        // Abort after 3 pixels
        sel = 1'b0;
        x_in = 8'd30; y_in = 7'd5; colour_in = 3'b110; erase = 1'b0;
        req_s = 1'b1;
        tick;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("abort_pix_valid", 32'(vs), 32'd1);
            check("abort_pix_x", 32'(xs), 32'(30 + k));
        end
        req_s = 1'b0;
        tick;
        check("abort_valid", 32'(vs), 32'd0);
        check("abort_done", 32'(ds), 32'd0);
        check("abort_x_hold", 32'(xs), 32'd32);
        tick;
        check("abort_idle_valid", 32'(vs), 32'd0);
        check("abort_idle_done", 32'(ds), 32'd0);
        run_plot(1'b0, 8'd30, 7'd5, 3'b110, 1'b0, 4, 2);

        // Reset at pixel 5, with an origin change mid-draw
        x_in = 8'd10; y_in = 7'd20; colour_in = 3'b001; erase = 1'b0;
        req_s = 1'b1;
        tick;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) x_in = 8'd50;
            tick;
            check("rstmid_pix_x", 32'(xs), 32'(10 + k % 4));
            check("rstmid_pix_y", 32'(ys), 32'(20 + k / 4));
        end
        resetn = 1'b1;
        tick;
        check("rstmid_x", 32'(xs), 32'd0);
        check("rstmid_y", 32'(ys), 32'd0);
        check("rstmid_c", 32'(cs), 32'd0);
        check("rstmid_v", 32'(vs), 32'd0);
        check("rstmid_d", 32'(ds), 32'd0);
        resetn = 1'b0;
        tick;
        check("rstmid_fresh_v", 32'(vs), 32'd0);
        tick;
        check("rstmid_restart_v", 32'(vs), 32'd1);
        check("rstmid_restart_x", 32'(xs), 32'd50);
        check("rstmid_restart_y", 32'(ys), 32'd20);
        req_s = 1'b0;
        tick;
        check("rstmid_abort_v", 32'(vs), 32'd0);

        // Reset wins over a simultaneous request in IDLE
        x_in = 8'd77; y_in = 7'd3;
        resetn = 1'b1; req_s = 1'b1;
        tick;
        check("rstprio_v", 32'(vs), 32'd0);
        resetn = 1'b0;
        tick;
        check("rstprio_no_pixel", 32'(vs), 32'd0);
        tick;
        check("rstprio_first_v", 32'(vs), 32'd1);
        check("rstprio_first_x", 32'(xs), 32'd77);
        req_s = 1'b0;
        tick;

        // Random small plots
        repeat (6) begin
            run_plot(1'b0, 8'($urandom), 7'($urandom), 3'($urandom), 1'($urandom), 4, 2);
        end

        // Default-size instance: 80 pixels, then done
        run_plot(1'b1, 8'($urandom), 7'($urandom), 3'($urandom), 1'b0, 20, 4);
        run_plot(1'b1, 8'd250, 7'd126, 3'b100, 1'b1, 20, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
